// File: rtl/led_pkg.sv
// Shared types and helpers for the LED matrix scan controller.
package led_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int LVL_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DISPLAY,
        WR_ADDR,
        WR_PULSE,
        WR_ACK
    } state_t;

    function automatic logic [7:0] bin_to_onehot8(input logic [2:0] bin);
        return 8'b1 << bin;
    endfunction

endpackage

// File: rtl/led_row_pwm.sv
// Row shadow register and 16-level PWM generator. Holds the eight brightness
// levels of the row being displayed and produces raw (active-high) column enables.
module led_row_pwm
    import led_pkg::*;
#(
    parameter int PWM_STEP_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic             cap_en,
    input  logic [2:0]       cap_idx,
    input  logic [LVL_W-1:0] cap_data,
    output logic [COLS-1:0]  col_en
);

    localparam int STEP_W = (PWM_STEP_CYC > 1) ? $clog2(PWM_STEP_CYC) : 1;
    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(PWM_STEP_CYC - 1);

    logic [LVL_W-1:0]  shadow [COLS];
    logic [LVL_W-1:0]  pwm_cnt;
    logic [STEP_W-1:0] step_cnt;

    // Shadow capture during fetch; step down-counter advances pwm_cnt on terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < COLS; i++) begin
                shadow[i] <= '0;
            end
            pwm_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            if (cap_en) begin
                shadow[cap_idx] <= cap_data;
            end
            if (clear) begin
                pwm_cnt  <= '0;
                step_cnt <= STEP_RELOAD;
            end else if (run) begin
                if (step_cnt == '0) begin
                    step_cnt <= STEP_RELOAD;
                    pwm_cnt  <= pwm_cnt + LVL_W'(1);
                end else begin
                    step_cnt <= step_cnt - STEP_W'(1);
                end
            end
        end
    end

    // Level L is lit for L of the 16 PWM steps; level 0 never lights.
    always_comb begin
        col_en = '0;
        for (int c = 0; c < COLS; c++) begin
            col_en[c] = (pwm_cnt < shadow[c]);
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// LED matrix scan sequencer and RAM port arbiter. Fetches one row at a time
// into the PWM shadow, dwells on it, and slips host writes into the dwell time.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | matrix blanked; waits for a write request or scan_en
//   FETCH    | 9 cycles: present 8 column addresses of row r, capture read data
//   DISPLAY  | drive row r with PWM columns until the dwell expires
//   WR_ADDR  | host address/data registered toward the RAM, we low
//   WR_PULSE | we high for exactly one cycle (RAM commits on we rising edge)
//   WR_ACK   | we low, wr_ack pulse, then resume scanning or go idle
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int PWM_STEP_CYC = 64,
    parameter int ROW_ACT_LOW  = 0,
    parameter int COL_ACT_LOW  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_en,
    input  logic             wr_req,
    input  logic [2:0]       wr_row,
    input  logic [2:0]       wr_col,
    input  logic [LVL_W-1:0] wr_data,
    output logic             wr_ack,
    output logic [ROWS-1:0]  ram_addr_row,
    output logic [COLS-1:0]  ram_addr_col,
    output logic [LVL_W-1:0] ram_data,
    output logic             ram_we,
    input  logic [LVL_W-1:0] ram_led_data,
    output logic [ROWS-1:0]  row_drv,
    output logic [COLS-1:0]  col_drv,
    output logic             frame_start
);

    localparam int DWELL_CYC = 16 * PWM_STEP_CYC;
    localparam int DWELL_W   = $clog2(DWELL_CYC);
    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_CYC - 1);
    localparam logic [3:0] FETCH_LAST = 4'd8;

    state_t             state, state_d;
    logic [2:0]         row_q, row_d;
    logic [3:0]         idx_q, idx_d;
    logic               scanning_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_done;
    logic               in_dwell;

    logic               pwm_clear;
    logic               cap_en;
    logic [2:0]         cap_idx;
    logic [COLS-1:0]    col_en;

    logic [ROWS-1:0]    addr_row_d;
    logic [COLS-1:0]    addr_col_d;
    logic [LVL_W-1:0]   data_d;
    logic               we_d;
    logic               ack_d;
    logic               show_row;
    logic [ROWS-1:0]    row_raw;
    logic [COLS-1:0]    col_raw;

    // State register; scanning_q remembers whether a write interrupted an active scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_q      <= '0;
            idx_q      <= '0;
            scanning_q <= 1'b0;
        end else begin
            state <= state_d;
            row_q <= row_d;
            idx_q <= idx_d;
            if (state_d == FETCH) begin
                scanning_q <= 1'b1;
            end else if (state_d == IDLE) begin
                scanning_q <= 1'b0;
            end
        end
    end

    // Next-state decision; a dwell that expired during a write is honoured at WR_ACK.
    always_comb begin
        state_d = state;
        row_d   = row_q;
        idx_d   = idx_q;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    state_d = WR_ADDR;
                end else if (scan_en) begin
                    state_d = FETCH;
                    row_d   = '0;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                if (idx_q == FETCH_LAST) begin
                    state_d = DISPLAY;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DISPLAY: begin
                if (!scan_en) begin
                    state_d = IDLE;
                end else if (dwell_done) begin
                    state_d = FETCH;
                    row_d   = row_q + 3'd1;
                    idx_d   = '0;
                end else if (wr_req) begin
                    state_d = WR_ADDR;
                end
            end
            WR_ADDR:  state_d = WR_PULSE;
            WR_PULSE: state_d = WR_ACK;
            WR_ACK: begin
                if (!scan_en || !scanning_q) begin
                    state_d = IDLE;
                end else if (dwell_done) begin
                    state_d = FETCH;
                    row_d   = row_q + 3'd1;
                    idx_d   = '0;
                end else begin
                    state_d = DISPLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Dwell down-counter: reloaded throughout FETCH, parks at zero so expiry is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (state == FETCH) begin
            dwell_cnt <= DWELL_RELOAD;
        end else if (in_dwell && (dwell_cnt != '0)) begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
    end

    // Control strobes for the row/PWM datapath.
    always_comb begin
        in_dwell   = (state inside {DISPLAY, WR_ADDR, WR_PULSE, WR_ACK});
        dwell_done = (dwell_cnt == '0);
        pwm_clear  = (state == FETCH);
        cap_en     = (state == FETCH) && (idx_q != 4'd0);
        cap_idx    = 3'(idx_q - 4'd1);
    end

    led_row_pwm #(
        .PWM_STEP_CYC (PWM_STEP_CYC)
    ) u_row_pwm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (pwm_clear),
        .run      (in_dwell),
        .cap_en   (cap_en),
        .cap_idx  (cap_idx),
        .cap_data (ram_led_data),
        .col_en   (col_en)
    );

    // Output decode: next values for the registered RAM port, plus the matrix drives.
    always_comb begin
        addr_row_d = ram_addr_row;
        addr_col_d = ram_addr_col;
        data_d     = ram_data;
        if ((state_d == FETCH) && !idx_d[3]) begin
            addr_row_d = bin_to_onehot8(row_d);
            addr_col_d = bin_to_onehot8(idx_d[2:0]);
        end else if (state_d == WR_ADDR) begin
            addr_row_d = bin_to_onehot8(wr_row);
            addr_col_d = bin_to_onehot8(wr_col);
            data_d     = wr_data;
        end
        we_d  = (state_d == WR_PULSE);
        ack_d = (state_d == WR_ACK);

        show_row = (state == FETCH) || (in_dwell && scanning_q);
        row_raw  = show_row ? bin_to_onehot8(row_q) : '0;
        col_raw  = (show_row && (state != FETCH)) ? col_en : '0;
        row_drv  = (ROW_ACT_LOW != 0) ? ~row_raw : row_raw;
        col_drv  = (COL_ACT_LOW != 0) ? ~col_raw : col_raw;

        frame_start = (state == FETCH) && (idx_q == 4'd0) && (row_q == 3'd0);
    end

    // RAM-facing outputs are registered so the RAM sees clean one-hot addresses and we.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr_row <= 8'h01;
            ram_addr_col <= 8'h01;
            ram_data     <= '0;
            ram_we       <= 1'b0;
            wr_ack       <= 1'b0;
        end else begin
            ram_addr_row <= addr_row_d;
            ram_addr_col <= addr_col_d;
            ram_data     <= data_d;
            ram_we       <= we_d;
            wr_ack       <= ack_d;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with a behavioural LED RAM and a write scoreboard.
module tb_led_scan_ctrl;

    localparam int P = 4;

    logic       clk;
    logic       rst_n;
    logic       scan_en;
    logic       wr_req;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic [7:0] ram_addr_row;
    logic [7:0] ram_addr_col;
    logic [3:0] ram_data;
    logic       ram_we;
    logic [3:0] ram_led_data;
    logic [7:0] row_drv;
    logic [7:0] col_drv;
    logic       frame_start;

    logic       ram_clr;
    logic       we_q;
    logic [3:0] mem [8][8];

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] c;
        logic [3:0] d;
    } wr_t;

    wr_t exp_q[$];

    int checks;
    int errors;
    int cyc;
    int we_cnt;
    int last_we_cyc;

    led_scan_ctrl #(
        .PWM_STEP_CYC (P),
        .ROW_ACT_LOW  (0),
        .COL_ACT_LOW  (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_en      (scan_en),
        .wr_req       (wr_req),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .ram_addr_row (ram_addr_row),
        .ram_addr_col (ram_addr_col),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .ram_led_data (ram_led_data),
        .row_drv      (row_drv),
        .col_drv      (col_drv),
        .frame_start  (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] oh(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Behavioural RAM: write on we rising edge, registered read one cycle after address.
    always @(posedge clk) begin
        we_q <= ram_we;
        if (ram_clr) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    mem[i][j] <= 4'd0;
                end
            end
            mem[0][3] <= 4'd15;
            mem[3][4] <= 4'd10;
            mem[7][1] <= 4'd1;
        end else if (ram_we && !we_q) begin
            mem[oh(ram_addr_row)][oh(ram_addr_col)] <= ram_data;
        end
        ram_led_data <= mem[oh(ram_addr_row)][oh(ram_addr_col)];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; any we pulse there is matched against the scoreboard.
    task automatic step();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (ram_we === 1'b1) begin
            we_cnt++;
            last_we_cyc = cyc;
            chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_addr_row", 32'(ram_addr_row), 32'(e.r));
                chk("sb_addr_col", 32'(ram_addr_col), 32'(e.c));
                chk("sb_data", 32'(ram_data), 32'(e.d));
            end
        end
    endtask

    task automatic request(input logic [2:0] r, input logic [2:0] c, input logic [3:0] d);
        wr_t e;
        wr_row  = r;
        wr_col  = c;
        wr_data = d;
        wr_req  = 1'b1;
        e.r = 8'd1 << r;
        e.c = 8'd1 << c;
        e.d = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;
        int bad;
        int cnt;
        int other;
        int ack_i;
        int base_we;
        int we_fetch;

        checks = 0; errors = 0; cyc = 0; we_cnt = 0; last_we_cyc = 0;
        rst_n = 1'b0; scan_en = 1'b0; wr_req = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; ram_clr = 1'b1;
        repeat (3) step();

        chk("rst_addr_row", 32'(ram_addr_row), 32'h01);
        chk("rst_addr_col", 32'(ram_addr_col), 32'h01);
        chk("rst_ram_data", 32'(ram_data), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_wr_ack", 32'(wr_ack), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_row_drv", 32'(row_drv), 0);
        chk("rst_col_drv", 32'(col_drv), 0);

        // 1: first frame, row 0 with col3 at level 15
        ram_clr = 1'b0; rst_n = 1'b1; scan_en = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            if (frame_start === 1'b1) found = 1;
        end
        chk("t1_frame_start_seen", found, 1);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (row_drv !== 8'h01 || col_drv !== 8'h00) bad++;
            if (frame_start !== (i == 0)) bad++;
            step();
        end
        chk("t1_fetch_blank", bad, 0);
        cnt = 0; other = 0; bad = 0;
        for (int i = 0; i < 16 * P; i++) begin
            if (col_drv[3] === 1'b1) cnt++;
            if ((col_drv & 8'hF7) !== 8'h00) other++;
            if (row_drv !== 8'h01) bad++;
            step();
        end
        chk("t1_col3_on_cycles", cnt, 15 * P);
        chk("t1_other_cols_off", other, 0);
        chk("t1_row0_drive", bad, 0);
        chk("t1_next_row_drv", 32'(row_drv), 32'h02);
        chk("t1_next_row_blank", 32'(col_drv), 0);

        // 2: write row 2 col 5 level 9 during row 1 display
        repeat (20) step();
        request(3'd2, 3'd5, 4'd9);
        base_we = we_cnt;
        ack_i = -1;
        for (int i = 0; i < 13 && ack_i < 0; i++) begin
            step();
            if (wr_ack === 1'b1) begin
                ack_i = i;
                chk("t2_ack_addr_held", 32'(ram_addr_row), 32'h04);
                chk("t2_ack_data_held", 32'(ram_data), 9);
                chk("t2_ack_after_we", cyc - last_we_cyc, 1);
                wr_req = 1'b0;
            end
        end
        chk("t2_ack_latency", ack_i, 2);
        chk("t2_we_pulses", we_cnt - base_we, 1);
        step();
        chk("t2_ack_one_cycle", 32'(wr_ack), 0);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            if (row_drv === 8'h04) found = 1;
        end
        chk("t2_row2_reached", found, 1);
        repeat (9) step();
        cnt = 0;
        for (int i = 0; i < 16 * P; i++) begin
            if (col_drv[5] === 1'b1) cnt++;
            step();
        end
        chk("t2_col5_duty", cnt, 9 * P);

        // 3: request at FETCH idx 0 of row 3; write is held off until DISPLAY
        chk("t3_row3_fetch", 32'(row_drv), 32'h08);
        request(3'd3, 3'd4, 4'd2);
        we_fetch = 0; ack_i = -1; cnt = 0;
        for (int i = 0; i < 9 + 16 * P; i++) begin
            if (i < 9 && ram_we === 1'b1) we_fetch++;
            if (col_drv[4] === 1'b1) cnt++;
            if (wr_ack === 1'b1 && ack_i < 0) begin
                ack_i = i;
                wr_req = 1'b0;
            end
            step();
        end
        chk("t3_no_we_in_fetch", we_fetch, 0);
        chk("t3_ack_latency", ack_i, 12);
        chk("t3_shadow_intact", cnt, 10 * P);
        chk("t3_row4_next", 32'(row_drv), 32'h10);

        // 4: row 7 level 1 and frame wrap
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (row_drv === 8'h80) found = 1;
        end
        chk("t4_row7_reached", found, 1);
        cnt = 0;
        for (int i = 0; i < 9 + 16 * P; i++) begin
            if (col_drv[1] === 1'b1) cnt++;
            step();
        end
        chk("t4_level1_cycles", cnt, P);
        chk("t4_wrap_frame_start", 32'(frame_start), 1);
        chk("t4_wrap_row0", 32'(row_drv), 32'h01);

        // 5: scan_en drops mid-DISPLAY while a write is requested
        repeat (30) step();
        scan_en = 1'b0;
        request(3'd6, 3'd7, 4'd3);
        step();
        chk("t5_idle_row_drv", 32'(row_drv), 0);
        chk("t5_idle_col_drv", 32'(col_drv), 0);
        ack_i = -1; bad = 0;
        for (int i = 0; i < 6 && ack_i < 0; i++) begin
            step();
            if (row_drv !== 8'h00 || col_drv !== 8'h00) bad++;
            if (wr_ack === 1'b1) begin
                ack_i = i;
                wr_req = 1'b0;
            end
        end
        chk("t5_ack_latency", ack_i, 2);
        chk("t5_drives_blank", bad, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (frame_start !== 1'b0 || row_drv !== 8'h00) bad++;
        end
        chk("t5_stays_idle", bad, 0);
        chk("t5_mem_r6c7", 32'(mem[6][7]), 3);
        chk("t5_mem_r2c5", 32'(mem[2][5]), 9);
        chk("t5_mem_r3c4", 32'(mem[3][4]), 2);

        // 6: reset lands during WR_PULSE
        request(3'd1, 3'd1, 4'd5);
        step();
        step();
        chk("t6_we_in_pulse", 32'(ram_we), 1);
        rst_n = 1'b0;
        wr_req = 1'b0;
        step();
        chk("t6_rst_we", 32'(ram_we), 0);
        chk("t6_rst_ack", 32'(wr_ack), 0);
        chk("t6_rst_row_drv", 32'(row_drv), 0);
        chk("t6_rst_col_drv", 32'(col_drv), 0);
        chk("t6_rst_addr_row", 32'(ram_addr_row), 32'h01);
        rst_n = 1'b1;
        scan_en = 1'b1;
        step();
        chk("t6_idle_to_fetch", 32'(frame_start), 1);

        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
